instr_fetch: RTL and testbench

Instruction fetch and sequencing unit for the LBD ISA v1.0 datapath. It holds the program counter and reads instruction ROM. Each cycle it presents the current instruction's 3-bit opcode to the control decoder. It closes the loop on the decoder's branch output: a taken branch redirects the PC and squashes the already-fetched instruction. It also detects program end, either the halt word or running off the program, and keeps cycle and retired-instruction counters.

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch and sequencing unit: owns the PC and IR, squashes on taken branches,
// detects HALT or running off the program, and keeps saturating cycle/retire counters.
module instr_fetch #(
    parameter int unsigned   IW       = 9,
    parameter int unsigned   OPW      = 3,
    parameter int unsigned   PCW      = 10,
    parameter int unsigned   PROG_LEN = 1024,
    parameter logic [IW-1:0] HALT     = 9'h1FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Taken,
    input  logic [PCW-1:0]    Target,
    input  logic [IW-1:0]     InstrIn,
    output logic [PCW-1:0]    PC,
    output logic [OPW-1:0]    ALUOp,
    output logic [IW-OPW-1:0] Operand,
    output logic              Valid,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       CycleCount,
    output logic [15:0]       InstrCount
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // One extra bit so PROG_LEN == 2^PCW is representable and never reached.
    localparam logic [PCW:0] ProgLenW = (PCW + 1)'(PROG_LEN);

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [15:0]     icnt_q, icnt_d;

    logic            pc_end;
    logic [15:0]     cyc_inc;
    logic [15:0]     icnt_inc;

    always_comb begin
        pc_end   = ({1'b0, pc_q} >= ProgLenW);
        cyc_inc  = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        icnt_inc = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;

        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        done_d  = done_q;
        cyc_d   = cyc_q;
        icnt_d  = icnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    cyc_d   = '0;
                    icnt_d  = '0;
                end
            end
            StRun: begin
                cyc_d = cyc_inc;
                if (!Stall) begin
                    if (valid_q && ir_q == HALT) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (valid_q && Branch && Taken) begin
                        // The instruction fetched behind the branch is dropped: one bubble.
                        pc_d    = Target;
                        valid_d = 1'b0;
                        icnt_d  = icnt_inc;
                    end else if (pc_end) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                        if (valid_q) icnt_d = icnt_inc;
                    end else begin
                        ir_d    = InstrIn;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PCW'(1);
                        if (valid_q) icnt_d = icnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            icnt_q  <= icnt_d;
        end
    end

    assign PC         = pc_q;
    assign ALUOp      = ir_q[IW-1:IW-OPW];
    assign Operand    = ir_q[IW-OPW-1:0];
    assign Valid      = valid_q;
    assign Busy       = (state_q == StRun);
    assign Done       = done_q;
    assign CycleCount = cyc_q;
    assign InstrCount = icnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized runs compared
// against a program-level reference model of fetch/retire sequencing.
module tb_instr_fetch;

    localparam logic [8:0] HaltW = 9'h1FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, stall, taken, br_en, br_force;
    logic [9:0] target;
    logic [8:0] rom [0:1023];
    logic [8:0] instr;
    logic       branch;
    logic [9:0] pc;
    logic [2:0] alu_op;
    logic [5:0] operand;
    logic       valid, busy, done;
    logic [15:0] cyc, icnt;

    // Second instance with a 4-word program and no HALT.
    logic       e_start;
    logic [8:0] rom_e [0:7];
    logic [8:0] e_instr;
    logic [9:0] e_pc;
    logic [2:0] e_alu_op;
    logic [5:0] e_operand;
    logic       e_valid, e_busy, e_done;
    logic [15:0] e_cyc, e_icnt;

    int n_checks, n_fail;

    assign instr   = rom[pc];
    assign e_instr = rom_e[e_pc[2:0]];
    // Decoder stand-in: opcode 011 is a branch.
    assign branch  = br_force | (br_en & (alu_op == 3'b011));

    instr_fetch dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Stall(stall), .Branch(branch),
        .Taken(taken), .Target(target), .InstrIn(instr), .PC(pc), .ALUOp(alu_op),
        .Operand(operand), .Valid(valid), .Busy(busy), .Done(done),
        .CycleCount(cyc), .InstrCount(icnt)
    );

    instr_fetch #(.PROG_LEN(4)) dut_e (
        .Clk(clk), .Reset_n(rst_n), .Start(e_start), .Stall(1'b0), .Branch(1'b0),
        .Taken(1'b0), .Target(10'd0), .InstrIn(e_instr), .PC(e_pc), .ALUOp(e_alu_op),
        .Operand(e_operand), .Valid(e_valid), .Busy(e_busy), .Done(e_done),
        .CycleCount(e_cyc), .InstrCount(e_icnt)
    );

    typedef struct {
        int         run;     // 0 idle, 1 running, 2 finished
        int         pc;
        logic [8:0] ir;
        bit         valid;
        bit         done;
        int         cyc;
        int         icnt;
    } model_t;

    model_t m;

    task automatic m_reset(inout model_t s);
        s.run = 0; s.pc = 0; s.ir = '0; s.valid = 0; s.done = 0; s.cyc = 0; s.icnt = 0;
    endtask

    task automatic m_step(inout model_t s, input bit st_in, input bit stl, input bit br,
                          input bit tk, input int tgt, input logic [8:0] word);
        if (s.run != 1) begin
            if (st_in) begin
                s.run = 1; s.pc = 0; s.valid = 0; s.done = 0; s.cyc = 0; s.icnt = 0;
            end
        end else begin
            if (s.cyc < 65535) s.cyc++;
            if (!stl) begin
                if (s.valid && s.ir == HaltW) begin
                    s.valid = 0; s.done = 1; s.run = 2;
                end else if (s.valid && br && tk) begin
                    s.pc = tgt; s.valid = 0;
                    if (s.icnt < 65535) s.icnt++;
                end else begin
                    if (s.valid && s.icnt < 65535) s.icnt++;
                    s.ir = word; s.valid = 1; s.pc = (s.pc + 1) % 1024;
                end
            end
        end
    endtask

    function automatic logic [8:0] rand_plain();
        logic [8:0] w;
        do w = 9'($urandom); while (w[8:6] == 3'b011 || w == HaltW);
        return w;
    endfunction

    task automatic fill_plain();
        for (int i = 0; i < 1024; i++) rom[i] = rand_plain();
    endtask

    // One clock: capture pre-edge inputs, advance DUT and model, land 1 time unit past the edge.
    task automatic cycle();
        logic [8:0] w;
        bit br, st, stl, tk;
        int tg;
        w   = rom[m.pc];
        br  = br_force || (br_en && m.ir[8:6] == 3'b011);
        st  = start; stl = stall; tk = taken; tg = int'(target);
        @(posedge clk); #1;
        if (rst_n) m_step(m, st, stl, br, tk, tg, w);
    endtask

    task automatic launch();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_reset(m);
        start = 0; e_start = 0; stall = 0; taken = 0; br_en = 0; br_force = 0; target = '0;
    endtask

    task automatic test_reset();
        logic [8:0] r0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks += 6;
        if (pc !== 10'd0)     begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
        if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (cyc !== 16'd0)    begin n_fail++; $display("FAIL reset_cyc: got %0d want 0", cyc); end
        if (icnt !== 16'd0)   begin n_fail++; $display("FAIL reset_icnt: got %0d want 0", icnt); end
        fill_plain();
        r0 = rom[0];
        launch();
        n_checks += 2;
        if (busy !== 1'b1)  begin n_fail++; $display("FAIL launch_busy: got %b want 1", busy); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL launch_valid0: got %b want 0", valid); end
        cycle();
        n_checks += 3;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL launch_valid1: got %b want 1", valid); end
        if ({alu_op, operand} !== r0)
            begin n_fail++; $display("FAIL launch_ir: got %h want %h", {alu_op, operand}, r0); end
        if (pc !== 10'd1)   begin n_fail++; $display("FAIL launch_pc: got %0d want 1", pc); end
        repeat (3) cycle();
        // Mid-RUN asynchronous reset, checked between clock edges.
        #3 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (pc !== 10'd0)   begin n_fail++; $display("FAIL async_pc: got %0d want 0", pc); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", valid); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
        if (cyc !== 16'd0)  begin n_fail++; $display("FAIL async_cyc: got %0d want 0", cyc); end
        if (icnt !== 16'd0) begin n_fail++; $display("FAIL async_icnt: got %0d want 0", icnt); end
        #1 rst_n = 1'b1;
        m_reset(m);
    endtask

    task automatic test_straight_line();
        do_reset();
        fill_plain();
        rom[5] = HaltW;
        launch();
        for (int k = 1; k <= 5; k++) begin
            cycle();
            n_checks += 3;
            if (valid !== 1'b1) begin n_fail++; $display("FAIL line_valid%0d: got %b want 1", k, valid); end
            if (pc !== 10'(k))  begin n_fail++; $display("FAIL line_pc%0d: got %0d want %0d", k, pc, k); end
            if (alu_op !== rom[k-1][8:6])
                begin n_fail++; $display("FAIL line_op%0d: got %b want %b", k, alu_op, rom[k-1][8:6]); end
        end
        cycle();
        cycle();
        n_checks += 5;
        if (done !== 1'b1)   begin n_fail++; $display("FAIL line_done: got %b want 1", done); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL line_busy: got %b want 0", busy); end
        if (valid !== 1'b0)  begin n_fail++; $display("FAIL line_valid_end: got %b want 0", valid); end
        if (icnt !== 16'd5)  begin n_fail++; $display("FAIL line_icnt: got %0d want 5", icnt); end
        if (cyc !== 16'd7)   begin n_fail++; $display("FAIL line_cyc: got %0d want 7", cyc); end
        cycle();
        n_checks++;
        if (done !== 1'b1)   begin n_fail++; $display("FAIL line_done_hold: got %b want 1", done); end
    endtask

    task automatic branch_prog();
        fill_plain();
        rom[2]  = {3'b011, 6'($urandom)};
        rom[10] = HaltW;
    endtask

    task automatic test_taken_branch();
        bit saw3;
        do_reset();
        branch_prog();
        br_en = 1; taken = 1; target = 10'd8;
        launch();
        repeat (3) cycle();
        cycle();
        n_checks += 2;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL tk_bubble: got %b want 0", valid); end
        if (pc !== 10'd8)   begin n_fail++; $display("FAIL tk_pc: got %0d want 8", pc); end
        cycle();
        n_checks += 2;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL tk_valid: got %b want 1", valid); end
        if ({alu_op, operand} !== rom[8])
            begin n_fail++; $display("FAIL tk_ir: got %h want %h", {alu_op, operand}, rom[8]); end
        saw3 = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            if (valid && pc == 10'd4) saw3 = 1;
        end
        n_checks += 3;
        if (saw3)           begin n_fail++; $display("FAIL tk_rom3_seen: got 1 want 0"); end
        if (done !== 1'b1)  begin n_fail++; $display("FAIL tk_done: got %b want 1", done); end
        if (icnt !== 16'd5) begin n_fail++; $display("FAIL tk_icnt: got %0d want 5", icnt); end
        br_en = 0; taken = 0;
    endtask

    task automatic test_not_taken();
        do_reset();
        branch_prog();
        br_en = 1; taken = 0; target = 10'd8;
        launch();
        repeat (4) cycle();
        n_checks += 3;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL nt_valid: got %b want 1", valid); end
        if (pc !== 10'd4)   begin n_fail++; $display("FAIL nt_pc: got %0d want 4", pc); end
        if ({alu_op, operand} !== rom[3])
            begin n_fail++; $display("FAIL nt_ir: got %h want %h", {alu_op, operand}, rom[3]); end
        for (int k = 0; k < 30 && !done; k++) cycle();
        n_checks += 2;
        if (done !== 1'b1)   begin n_fail++; $display("FAIL nt_done: got %b want 1", done); end
        if (icnt !== 16'd10) begin n_fail++; $display("FAIL nt_icnt: got %0d want 10", icnt); end
        br_en = 0;
    endtask

    task automatic test_stall();
        do_reset();
        fill_plain();
        rom[4]  = {3'b011, 6'($urandom)};
        rom[12] = HaltW;
        br_en = 1; taken = 0; target = 10'd0;
        launch();
        repeat (5) cycle();
        stall = 1; taken = 1;
        repeat (3) cycle();
        n_checks += 5;
        if (pc !== 10'd5)   begin n_fail++; $display("FAIL st_pc: got %0d want 5", pc); end
        if (valid !== 1'b1) begin n_fail++; $display("FAIL st_valid: got %b want 1", valid); end
        if ({alu_op, operand} !== rom[4])
            begin n_fail++; $display("FAIL st_ir: got %h want %h", {alu_op, operand}, rom[4]); end
        if (icnt !== 16'd4) begin n_fail++; $display("FAIL st_icnt: got %0d want 4", icnt); end
        if (cyc !== 16'd8)  begin n_fail++; $display("FAIL st_cyc: got %0d want 8", cyc); end
        stall = 0; taken = 0;
        cycle();
        n_checks += 3;
        if (pc !== 10'd6)   begin n_fail++; $display("FAIL st_resume_pc: got %0d want 6", pc); end
        if ({alu_op, operand} !== rom[5])
            begin n_fail++; $display("FAIL st_resume_ir: got %h want %h", {alu_op, operand}, rom[5]); end
        if (icnt !== 16'd5) begin n_fail++; $display("FAIL st_resume_icnt: got %0d want 5", icnt); end
        br_en = 0;
        for (int k = 0; k < 30 && !done; k++) cycle();
        n_checks++;
        if (done !== 1'b1)  begin n_fail++; $display("FAIL st_done: got %b want 1", done); end
    endtask

    task automatic test_end_of_program();
        do_reset();
        for (int i = 0; i < 8; i++) rom_e[i] = rand_plain();
        e_start = 1; cycle(); e_start = 0;
        repeat (4) cycle();
        n_checks += 2;
        if (e_valid !== 1'b1) begin n_fail++; $display("FAIL eop_valid: got %b want 1", e_valid); end
        if (e_pc !== 10'd4)   begin n_fail++; $display("FAIL eop_pc: got %0d want 4", e_pc); end
        cycle();
        n_checks += 5;
        if (e_done !== 1'b1)  begin n_fail++; $display("FAIL eop_done: got %b want 1", e_done); end
        if (e_busy !== 1'b0)  begin n_fail++; $display("FAIL eop_busy: got %b want 0", e_busy); end
        if (e_valid !== 1'b0) begin n_fail++; $display("FAIL eop_valid_end: got %b want 0", e_valid); end
        if (e_icnt !== 16'd4) begin n_fail++; $display("FAIL eop_icnt: got %0d want 4", e_icnt); end
        if (e_cyc !== 16'd5)  begin n_fail++; $display("FAIL eop_cyc: got %0d want 5", e_cyc); end
        cycle();
        e_start = 1; cycle(); e_start = 0;
        n_checks += 5;
        if (e_done !== 1'b0)  begin n_fail++; $display("FAIL rerun_done: got %b want 0", e_done); end
        if (e_busy !== 1'b1)  begin n_fail++; $display("FAIL rerun_busy: got %b want 1", e_busy); end
        if (e_cyc !== 16'd0)  begin n_fail++; $display("FAIL rerun_cyc: got %0d want 0", e_cyc); end
        if (e_icnt !== 16'd0) begin n_fail++; $display("FAIL rerun_icnt: got %0d want 0", e_icnt); end
        if (e_pc !== 10'd0)   begin n_fail++; $display("FAIL rerun_pc: got %0d want 0", e_pc); end
        cycle();
        n_checks += 2;
        if (e_pc !== 10'd1)   begin n_fail++; $display("FAIL rerun_pc1: got %0d want 1", e_pc); end
        if ({e_alu_op, e_operand} !== rom_e[0])
            begin n_fail++; $display("FAIL rerun_ir: got %h want %h", {e_alu_op, e_operand}, rom_e[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        fill_plain();
        rom[1] = {3'b011, 6'($urandom)};
        br_en = 1; taken = 1; target = 10'd1022;
        launch();
        repeat (3) cycle();
        n_checks++;
        if (pc !== 10'd1022) begin n_fail++; $display("FAIL wrap_tgt: got %0d want 1022", pc); end
        br_en = 0; taken = 0;
        repeat (2) cycle();
        n_checks += 2;
        if (pc !== 10'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d want 0", pc); end
        if ({alu_op, operand} !== rom[1023])
            begin n_fail++; $display("FAIL wrap_ir: got %h want %h", {alu_op, operand}, rom[1023]); end
        cycle();
        n_checks += 2;
        if (pc !== 10'd1) begin n_fail++; $display("FAIL wrap_pc1: got %0d want 1", pc); end
        if ({alu_op, operand} !== rom[0])
            begin n_fail++; $display("FAIL wrap_ir0: got %h want %h", {alu_op, operand}, rom[0]); end
    endtask

    task automatic test_random();
        int r;
        for (int p = 0; p < 6; p++) begin
            do_reset();
            for (int i = 0; i < 1024; i++) begin
                r = $urandom_range(0, 99);
                if (r < 15)      rom[i] = {3'b011, 6'($urandom)};
                else if (r < 17) rom[i] = HaltW;
                else             rom[i] = rand_plain();
            end
            br_en = 1;
            for (int c = 0; c < 400; c++) begin
                start    = (c == 0) || ($urandom_range(0, 19) == 0);
                stall    = ($urandom_range(0, 3) == 0);
                taken    = 1'($urandom_range(0, 1));
                target   = 10'($urandom_range(0, 1023));
                br_force = ($urandom_range(0, 15) == 0);
                cycle();
                n_checks += 6;
                if (pc !== 10'(m.pc))
                    begin n_fail++; $display("FAIL rnd_pc p%0d c%0d: got %0d want %0d", p, c, pc, m.pc); end
                if (valid !== m.valid)
                    begin n_fail++; $display("FAIL rnd_valid p%0d c%0d: got %b want %b", p, c, valid, m.valid); end
                if (busy !== (m.run == 1))
                    begin n_fail++; $display("FAIL rnd_busy p%0d c%0d: got %b want %b", p, c, busy, m.run == 1); end
                if (done !== m.done)
                    begin n_fail++; $display("FAIL rnd_done p%0d c%0d: got %b want %b", p, c, done, m.done); end
                if (cyc !== 16'(m.cyc))
                    begin n_fail++; $display("FAIL rnd_cyc p%0d c%0d: got %0d want %0d", p, c, cyc, m.cyc); end
                if (icnt !== 16'(m.icnt))
                    begin n_fail++; $display("FAIL rnd_icnt p%0d c%0d: got %0d want %0d", p, c, icnt, m.icnt); end
                if (m.valid) begin
                    n_checks++;
                    if ({alu_op, operand} !== m.ir)
                        begin n_fail++; $display("FAIL rnd_ir p%0d c%0d: got %h want %h", p, c, {alu_op, operand}, m.ir); end
                end
            end
        end
        start = 0; stall = 0; taken = 0; br_force = 0; br_en = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        fill_plain();
        launch();
        for (int c = 0; c < 65540; c++) cycle();
        n_checks += 5;
        if (cyc !== 16'hFFFF)  begin n_fail++; $display("FAIL sat_cyc: got %h want ffff", cyc); end
        if (icnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_icnt: got %h want ffff", icnt); end
        if (icnt !== 16'(m.icnt))
            begin n_fail++; $display("FAIL sat_icnt_model: got %0d want %0d", icnt, m.icnt); end
        if (pc !== 10'(m.pc))  begin n_fail++; $display("FAIL sat_pc: got %0d want %0d", pc, m.pc); end
        if (busy !== 1'b1)     begin n_fail++; $display("FAIL sat_busy: got %b want 1", busy); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start = 0; e_start = 0; stall = 0; taken = 0;
        br_en = 0; br_force = 0; target = '0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        for (int i = 0; i < 8; i++) rom_e[i] = '0;
        m_reset(m);
        test_reset();
        test_straight_line();
        test_taken_branch();
        test_not_taken();
        test_stall();
        test_end_of_program();
        test_wrap();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
